// File: rtl/amax10_qsys_pio_pwm.sv
// ---------------------------------------------------------------------------
// amax10_qsys_pio_pwm
//
// Avalon-MM PIO block whose output channels can each be driven statically or
// by a shared PWM counter. Every channel has its own duty value. A duty write
// goes to a pending register. The pending value is copied to the active
// register only when the PWM counter wraps, so a duty change never cuts a
// period short.
//
// Parameters
//   WIDTH          number of output channels (1..32)
//   PWM_BITS       PWM counter / duty width (1..16)
//   PRESCALE_BITS  prescaler reload width (1..32)
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   address     Avalon word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   32-bit write data
//   readdata    32-bit read data, combinational from address, zero-extended
//   out_port    registered channel outputs
//
// Register map (word addresses)
//   0 DATA      RW  channel enable/level bits
//   1 MODE      RW  1 = PWM, 0 = static, per channel
//   2 OUTSET    WO  DATA |= writedata; reads 0
//   3 OUTCLR    WO  DATA &= ~writedata; reads 0
//   4 DUTY_SEL  RW  channel index (5 bits) used by DUTY
//   5 DUTY      RW  pending duty of channel DUTY_SEL (0 if index out of range)
//   6 PRESCALE  RW  prescaler reload; a write also restarts the prescaler
//   7 STATUS    RO  current PWM counter
// ---------------------------------------------------------------------------
module amax10_qsys_pio_pwm #(
  parameter int WIDTH         = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [WIDTH-1:0]     out_port
);

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_MODE     = 3'd1,
    ADDR_OUTSET   = 3'd2,
    ADDR_OUTCLR   = 3'd3,
    ADDR_DUTY_SEL = 3'd4,
    ADDR_DUTY     = 3'd5,
    ADDR_PRESCALE = 3'd6,
    ADDR_STATUS   = 3'd7
  } reg_addr_e;

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]         data_q;
  logic [WIDTH-1:0]         mode_q;
  logic [4:0]               duty_sel_q;
  logic [PWM_BITS-1:0]      pending_q [WIDTH];
  logic [PWM_BITS-1:0]      active_q  [WIDTH];
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic [PRESCALE_BITS-1:0] pre_cnt_q;
  logic [PWM_BITS-1:0]      pwm_cnt_q;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  reg_addr_e addr;
  logic      wr_en;
  logic      wr_data;
  logic      wr_mode;
  logic      wr_set;
  logic      wr_clr;
  logic      wr_sel;
  logic      wr_duty;
  logic      wr_prescale;

  assign addr        = reg_addr_e'(address);
  assign wr_en       = chipselect & ~write_n;
  assign wr_data     = wr_en && (addr == ADDR_DATA);
  assign wr_mode     = wr_en && (addr == ADDR_MODE);
  assign wr_set      = wr_en && (addr == ADDR_OUTSET);
  assign wr_clr      = wr_en && (addr == ADDR_OUTCLR);
  assign wr_sel      = wr_en && (addr == ADDR_DUTY_SEL);
  assign wr_duty     = wr_en && (addr == ADDR_DUTY);
  assign wr_prescale = wr_en && (addr == ADDR_PRESCALE);

  // Upper writedata bits are deliberately ignored; folding them here keeps
  // the intent explicit instead of leaving dangling inputs.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // -------------------------------------------------------------------------
  // Timebase: prescaler tick and PWM wrap
  // -------------------------------------------------------------------------
  logic tick;
  logic wrap;

  // With a reload of 0, pre_cnt sits at 0 and the compare holds every cycle.
  assign tick = (pre_cnt_q == prescale_q);
  assign wrap = tick && (pwm_cnt_q == PWM_MAX);

  // -------------------------------------------------------------------------
  // DATA / MODE / DUTY_SEL
  // -------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      mode_q     <= '0;
      duty_sel_q <= '0;
    end else begin
      if (wr_data) begin
        data_q <= writedata[WIDTH-1:0];
      end else if (wr_set) begin
        data_q <= data_q | writedata[WIDTH-1:0];
      end else if (wr_clr) begin
        data_q <= data_q & ~writedata[WIDTH-1:0];
      end

      if (wr_mode) begin
        mode_q <= writedata[WIDTH-1:0];
      end

      if (wr_sel) begin
        duty_sel_q <= writedata[4:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '1;
      pre_cnt_q  <= '0;
    end else if (wr_prescale) begin
      // Restart the count so the new reload takes effect from a known phase.
      prescale_q <= writedata[PRESCALE_BITS-1:0];
      pre_cnt_q  <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PRESCALE_BITS'(1);
    end
  end

  // -------------------------------------------------------------------------
  // PWM counter (wraps naturally at 2^PWM_BITS)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else if (tick) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel duty: pending (bus side) and active (compare side)
  // -------------------------------------------------------------------------
  // NOTE: these small register arrays are reset explicitly because the
  // outputs must be deterministic after reset; large RAM-style arrays would
  // normally be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        // An out-of-range DUTY_SEL matches no channel, so the write is dropped.
        if (wr_duty && (duty_sel_q == 5'(i))) begin
          pending_q[i] <= writedata[PWM_BITS-1:0];
        end
        // On a boundary that coincides with a DUTY write, the old pending
        // value is loaded; the new one waits for the next boundary.
        if (wrap) begin
          active_q[i] <= pending_q[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output generation
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] out_next;

  // NOTE: every signal written in a combinational block gets a default at the
  // top so no path can leave it unassigned and infer a latch.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_q[i]) begin
        out_next[i] = data_q[i] & (pwm_cnt_q < active_q[i]);
      end else begin
        out_next[i] = data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= out_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic [PWM_BITS-1:0] duty_rd;

  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (duty_sel_q == 5'(i)) begin
        duty_rd = pending_q[i];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (addr)
      ADDR_DATA:     readdata[WIDTH-1:0]         = data_q;
      ADDR_MODE:     readdata[WIDTH-1:0]         = mode_q;
      ADDR_DUTY_SEL: readdata[4:0]               = duty_sel_q;
      ADDR_DUTY:     readdata[PWM_BITS-1:0]      = duty_rd;
      ADDR_PRESCALE: readdata[PRESCALE_BITS-1:0] = prescale_q;
      ADDR_STATUS:   readdata[PWM_BITS-1:0]      = pwm_cnt_q;
      default:       readdata                    = '0;
    endcase
  end

endmodule

// File: tb/tb_amax10_qsys_pio_pwm.sv
// ---------------------------------------------------------------------------
// Testbench for amax10_qsys_pio_pwm (default parameters: 8 channels, 8-bit
// PWM, 16-bit prescaler). Directed steps plus randomized bus traffic, with
// outputs compared against a behavioural model written in terms of elapsed
// ticks and PWM periods.
// ---------------------------------------------------------------------------
module tb_amax10_qsys_pio_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  amax10_qsys_pio_pwm #(
    .WIDTH(8),
    .PWM_BITS(8),
    .PRESCALE_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: time is measured in prescaler ticks; the PWM position is
  // ticks mod 256 and a new period begins each time that reaches 0.
  // -------------------------------------------------------------------------
  logic [7:0]  m_data, m_mode, m_out;
  logic [4:0]  m_sel;
  logic [7:0]  m_pend [8];
  logic [7:0]  m_act  [8];
  logic [15:0] m_reload;
  int          m_phase;   // cycles since the prescaler last restarted
  int          m_ticks;   // ticks since reset

  always @(posedge clk) begin
    if (reset) begin
      m_data <= '0; m_mode <= '0; m_sel <= '0; m_out <= '0;
      m_reload <= 16'hFFFF; m_phase <= 0; m_ticks <= 0;
      for (int i = 0; i < 8; i++) begin
        m_pend[i] <= '0;
        m_act[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++)
        m_out[i] <= m_data[i] && (!m_mode[i] || ((m_ticks % 256) < int'(m_act[i])));
      if (m_phase == int'(m_reload)) begin
        m_phase <= 0;
        m_ticks <= m_ticks + 1;
        if ((m_ticks % 256) == 255)
          for (int i = 0; i < 8; i++) m_act[i] <= m_pend[i];
      end else begin
        m_phase <= m_phase + 1;
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[7:0];
          3'd1: m_mode <= writedata[7:0];
          3'd2: m_data <= m_data | writedata[7:0];
          3'd3: m_data <= m_data & ~writedata[7:0];
          3'd4: m_sel  <= writedata[4:0];
          3'd5: if (m_sel < 5'd8) m_pend[m_sel[2:0]] <= writedata[7:0];
          3'd6: begin m_reload <= writedata[15:0]; m_phase <= 0; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_mode};
      3'd4: return {27'd0, m_sel};
      3'd5: return (m_sel < 5'd8) ? {24'd0, m_pend[m_sel[2:0]]} : 32'd0;
      3'd6: return {16'd0, m_reload};
      3'd7: return 32'(m_ticks % 256);
      default: return 32'd0;
    endcase
  endfunction

  // Continuous output comparison against the model.
  always @(negedge clk) begin
    if (chk_on) check("out_port", {24'd0, out_port}, {24'd0, m_out});
  end

  // Edge monitor on channel 0 (cycle stamps of rises and falls).
  int   cyc = 0, n_rise = 0, n_fall = 0, last_rise = 0, prev_rise = 0, last_fall = 0;
  logic prev0 = 1'b0;
  always @(negedge clk) begin
    cyc   <= cyc + 1;
    prev0 <= out_port[0];
    if (chk_on && out_port[0] === 1'b1 && prev0 === 1'b0) begin
      prev_rise <= last_rise;
      last_rise <= cyc;
      n_rise    <= n_rise + 1;
    end
    if (chk_on && out_port[0] === 1'b0 && prev0 === 1'b1) begin
      last_fall <= cyc;
      n_fall    <= n_fall + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Bus helpers (all return at negedge + 1)
  // -------------------------------------------------------------------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input string tag);
    int n0; int k;
    n0 = n_rise; k = 0;
    while (n_rise == n0 && k < 1000) begin @(negedge clk); #1; k++; end
    check(tag, 32'(n_rise != n0), 32'd1);
  endtask

  task automatic wait_fall(input string tag);
    int n0; int k;
    n0 = n_fall; k = 0;
    while (n_fall == n0 && k < 1000) begin @(negedge clk); #1; k++; end
    check(tag, 32'(n_fall != n0), 32'd1);
  endtask

  // Number of cycles until STATUS changes (bounded at 20).
  task automatic status_gap(output int k);
    logic [31:0] s0;
    address = 3'd7;
    #1 s0 = readdata;
    k = 0;
    while (readdata === s0 && k < 20) begin @(negedge clk); #1; k++; end
  endtask

  logic [31:0] v;
  logic [2:0]  ra, wa;
  logic [31:0] wd;
  int          gap, n0;

  initial begin
    // ---------------- reset ----------------
    @(negedge clk); #1 chk_on = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_out", {24'd0, out_port}, 32'd0);
    rd(3'd0, v); check("rst_data", v, 32'd0);
    rd(3'd1, v); check("rst_mode", v, 32'd0);
    rd(3'd4, v); check("rst_sel", v, 32'd0);
    rd(3'd5, v); check("rst_duty", v, 32'd0);
    rd(3'd6, v); check("rst_prescale", v, 32'h0000FFFF);
    rd(3'd7, v); check("rst_status", v, 32'd0);

    // ---------------- DATA write and output latency ----------------
    wr(3'd0, 32'hA5);
    check("lat_before", {24'd0, out_port}, 32'd0);
    step(1);
    check("lat_after", {24'd0, out_port}, 32'hA5);
    rd(3'd0, v); check("data_a5", v, 32'hA5);

    // ---------------- OUTSET / OUTCLR ----------------
    wr(3'd0, 32'hF0);
    wr(3'd2, 32'h0F);
    rd(3'd0, v); check("outset", v, 32'hFF);
    wr(3'd3, 32'h81);
    rd(3'd0, v); check("outclr", v, 32'h7E);
    rd(3'd2, v); check("rd_outset", v, 32'd0);
    rd(3'd3, v); check("rd_outclr", v, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, v); check("status_ro", v, 32'd0);

    // ---------------- prescaler ----------------
    wr(3'd6, 32'd3);
    status_gap(gap); check("pre_gap1", 32'(gap), 32'd4);
    status_gap(gap); check("pre_gap2", 32'(gap), 32'd4);
    step(1);
    wr(3'd6, 32'd3);            // lands mid-count, restarts the prescaler
    status_gap(gap); check("pre_restart", 32'(gap), 32'd4);
    rd(3'd7, v); check("status_3", v, 32'd3);

    // ---------------- out-of-range DUTY_SEL ----------------
    wr(3'd4, 32'd9);
    wr(3'd5, 32'h55);
    rd(3'd5, v); check("duty_sel9_rd", v, 32'd0);
    rd(3'd4, v); check("duty_sel9_sel", v, 32'd9);
    wr(3'd4, 32'd1);
    rd(3'd5, v); check("duty_ch1_clean", v, 32'd0);

    // ---------------- PWM duty 64, period 256 ----------------
    wr(3'd6, 32'd0);
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd64);
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h01);
    wait_rise("pwm_rise1");
    wait_fall("pwm_fall1");
    check("pwm_high64", 32'(last_fall - last_rise), 32'd64);
    wait_rise("pwm_rise2");
    check("pwm_period", 32'(last_rise - prev_rise), 32'd256);

    // ---------------- duty change mid-period ----------------
    wr(3'd5, 32'd192);          // during the 64-high phase
    wait_fall("pwm_fall2");
    check("keep64", 32'(last_fall - last_rise), 32'd64);
    wait_rise("pwm_rise3");
    check("period2", 32'(last_rise - prev_rise), 32'd256);
    wait_fall("pwm_fall3");
    check("high192", 32'(last_fall - last_rise), 32'd192);
    wr(3'd5, 32'd0);
    n0 = n_rise;
    step(600);
    check("duty0_no_rise", 32'(n_rise), 32'(n0));
    check("duty0_low", {31'd0, out_port[0]}, 32'd0);

    // ---------------- randomized traffic ----------------
    for (int s = 0; s < 250; s++) begin
      wa = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (wa == 3'd6) wd = 32'($urandom_range(0, 3));
      if (wa == 3'd4) wd = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) wr(wa, wd);
      ra = 3'($urandom_range(0, 7));
      rd(ra, v);
      check("rand_rd", v, m_read(ra));
      step($urandom_range(0, 3));
    end

    // ---------------- reset mid-period with simultaneous write ----------------
    wr(3'd6, 32'd0);
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hFF);
    step(40);
    @(negedge clk); #1;
    reset = 1'b1; address = 3'd0; writedata = 32'h5A; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("rst2_out", {24'd0, out_port}, 32'd0);
    rd(3'd0, v); check("rst2_data", v, 32'd0);
    rd(3'd1, v); check("rst2_mode", v, 32'd0);
    rd(3'd4, v); check("rst2_sel", v, 32'd0);
    rd(3'd5, v); check("rst2_duty", v, 32'd0);
    rd(3'd6, v); check("rst2_prescale", v, 32'h0000FFFF);
    rd(3'd7, v); check("rst2_status", v, 32'd0);
    wr(3'd4, 32'd3);
    rd(3'd5, v); check("rst2_duty3", v, 32'd0);
    step(5);
    rd(3'd7, v); check("rst2_status_hold", v, 32'd0);
    check("rst2_out_hold", {24'd0, out_port}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amax10_qsys_pio_pwm.md
AMAX10_QSYS_PIO_PWM -- requirements
Module: amax10_qsys_pio_pwm

Interface
REQ-001 Parameter WIDTH, default 8: number of output channels, 1..32.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width, 1..16.
REQ-003 Parameter PRESCALE_BITS, default 16: prescaler reload register width, 1..32.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 address  input  3: Avalon-MM word address.
REQ-007 chipselect  input  1: slave select.
REQ-008 write_n  input  1: active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32: write data.
REQ-010 readdata  output  32: read data, zero-extended, combinational from address (0 wait states, 0 read latency).
REQ-011 out_port  output  WIDTH: registered channel outputs.

Function
REQ-012 Write occurs in a cycle with chipselect=1 and write_n=0; the written register updates on that clock edge.
REQ-013 Register map:
 - 0 DATA (RW, WIDTH): channel enable/level bits.
 - 1 MODE (RW, WIDTH): bit i=1 selects PWM for channel i; 0 selects static.
 - 2 OUTSET (WO): DATA <= DATA | writedata[WIDTH-1:0]; reads 0.
 - 3 OUTCLR (WO): DATA <= DATA & ~writedata[WIDTH-1:0]; reads 0.
 - 4 DUTY_SEL (RW, 5 bits): channel index for DUTY access.
 - 5 DUTY (RW, PWM_BITS): pending duty of channel DUTY_SEL.
 - 6 PRESCALE (RW, PRESCALE_BITS): prescaler reload value.
 - 7 STATUS (RO): bits[PWM_BITS-1:0]=pwm_cnt; writes ignored.
REQ-014 Unused readdata bits SHALL read 0; writes to RO/unused bits SHALL be ignored.
REQ-015 DUTY access with DUTY_SEL >= WIDTH: write ignored, read returns 0.
REQ-016 Prescaler: pre_cnt increments each cycle; when pre_cnt == PRESCALE, pre_cnt <= 0 and a one-cycle tick is asserted; PRESCALE=0 SHALL tick every cycle.
REQ-017 Write to PRESCALE SHALL also clear pre_cnt on the same edge.
REQ-018 pwm_cnt increments by 1 on each tick and wraps from 2^PWM_BITS-1 to 0 (period = 2^PWM_BITS ticks).
REQ-019 Each channel holds pending duty (written via DUTY) and active duty; active <= pending on the tick that wraps pwm_cnt to 0 (glitch-free period-boundary update).
REQ-020 Next output value: static channel = DATA[i]; PWM channel = DATA[i] & (pwm_cnt < active_duty[i]).
REQ-021 out_port SHALL register the REQ-020 value: one-cycle latency from DATA/MODE/pwm_cnt change to out_port.
REQ-022 Duty 0 SHALL give constant 0; duty 2^PWM_BITS-1 SHALL give high for all but the last tick-period of each PWM period.
REQ-023 DATA[i]=0 SHALL force channel i low regardless of MODE.
REQ-024 A PWM period boundary coinciding with a DUTY write SHALL load the previous pending value into active; the new value takes effect at the next boundary.

Reset
REQ-025 On reset: DATA, MODE, DUTY_SEL, all pending/active duties, pre_cnt, pwm_cnt = 0; PRESCALE = all ones; out_port = 0 on the following edge and thereafter until written.
REQ-026 Reset asserted mid-period SHALL abort the period; counting resumes from 0 the cycle after reset deasserts; reset takes priority over a simultaneous write.

Verification
REQ-027 Reset; write DATA=0xA5 -> out_port=0xA5 one cycle after the write edge; read DATA=0xA5.
REQ-028 DATA=0xF0; OUTSET 0x0F -> DATA=0xFF; OUTCLR 0x81 -> DATA=0x7E; reads of addresses 2/3 return 0.
REQ-029 PRESCALE=0, DUTY_SEL=0, DUTY=64, MODE=0x01, DATA=0x01 -> after next pwm_cnt wrap, out_port[0] high 64 cycles of every 256, period exactly 256 cycles.
REQ-030 Channel 0 in PWM duty 64; write DUTY=192 mid-period -> current period keeps 64-high; following period 192-high; duty 0 -> constant low.
REQ-031 PRESCALE=3 -> STATUS increments every 4 cycles; write PRESCALE mid-count -> next tick 4 cycles after the write; DUTY_SEL=9 (WIDTH=8) write DUTY -> ignored, read 0.
REQ-032 Assert reset for one cycle mid-PWM period with a simultaneous DATA write -> all registers at reset values, out_port=0, STATUS=0.
